// File: rtl/chain_sched_if.sv
// Port bundle between the chain sequencer and the DP solution memory.
// master = sequencer side, slave = memory side.
interface chain_sched_if #(
    parameter int CW = 32
);
    logic          mem_clr;
    logic          mem_rw;
    logic [7:0]    mem_iw;
    logic [7:0]    mem_jw;
    logic [CW-1:0] mem_min;
    logic [CW-1:0] mem_k;
    logic [7:0]    mem_ir;
    logic [7:0]    mem_jr;
    logic [7:0]    mem_kr;
    logic [CW-1:0] mem_mik;
    logic [CW-1:0] mem_mkj1;

    modport master (
        output mem_clr, mem_rw, mem_iw, mem_jw, mem_min, mem_k,
        output mem_ir, mem_jr, mem_kr,
        input  mem_mik, mem_mkj1
    );
    modport slave (
        input  mem_clr, mem_rw, mem_iw, mem_jw, mem_min, mem_k,
        input  mem_ir, mem_jr, mem_kr,
        output mem_mik, mem_mkj1
    );
endinterface

// File: rtl/chain_sched.sv
// Matrix-chain DP sequencer: fills the cost/split table bottom-up through the
// solution memory and reports m[1][n] with its top-level split.
module chain_sched #(
    parameter int MAXN  = 30,
    parameter int DIM_W = 16,
    parameter int CW    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dim_we,
    input  logic [4:0]       dim_addr,
    input  logic [DIM_W-1:0] dim_data,
    input  logic [4:0]       n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CW-1:0]    res_cost,
    output logic [CW-1:0]    res_k,
    chain_sched_if.master    m
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CLR   = 3'd1;
    localparam logic [2:0] SETUP = 3'd2;
    localparam logic [2:0] RD    = 3'd3;
    localparam logic [2:0] CMP   = 3'd4;
    localparam logic [2:0] WR    = 3'd5;
    localparam logic [2:0] DONE  = 3'd6;

    // Wide enough for the triple product plus both table terms without wrap.
    localparam int PW = (3*DIM_W > 2*CW) ? 3*DIM_W : 2*CW;
    localparam int FW = PW + 2;

    logic [2:0]       state;
    logic [4:0]       nl;
    logic [5:0]       len;
    logic [4:0]       i, j, k;
    logic [CW-1:0]    best, bestk;
    logic [DIM_W-1:0] p [32];

    logic [FW-1:0]    prod, sum;
    logic [CW-1:0]    cost;

    always_comb begin
        prod = FW'(p[i - 5'd1]) * FW'(p[k]) * FW'(p[j]);
        sum  = FW'(m.mem_mik) + FW'(m.mem_mkj1) + prod;
        cost = (sum > FW'({CW{1'b1}})) ? {CW{1'b1}} : sum[CW-1:0];
    end

    assign busy = (state != IDLE) && (state != DONE);
    assign done = (state == DONE);

    assign m.mem_clr = (state == CLR);
    assign m.mem_rw  = (state == WR);
    assign m.mem_iw  = 8'(i);
    assign m.mem_jw  = 8'(j);
    assign m.mem_min = best;
    assign m.mem_k   = bestk;
    assign m.mem_ir  = 8'(i);
    assign m.mem_jr  = 8'(j);
    assign m.mem_kr  = 8'(k);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            err      <= 1'b0;
            nl       <= '0;
            len      <= '0;
            i        <= '0;
            j        <= '0;
            k        <= '0;
            best     <= '0;
            bestk    <= '0;
            res_cost <= '0;
            res_k    <= '0;
            for (int a = 0; a < 32; a++) p[a] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dim_we && int'(dim_addr) <= MAXN) p[dim_addr] <= dim_data;
                    if (start) begin
                        if (int'(n) < 2 || int'(n) > MAXN) begin
                            err <= 1'b1;
                        end else begin
                            err   <= 1'b0;
                            nl    <= n;
                            state <= CLR;
                        end
                    end
                end
                CLR: begin
                    len   <= 6'd2;
                    i     <= 5'd1;
                    state <= SETUP;
                end
                SETUP: begin
                    j     <= 5'(6'(i) + len - 6'd1);
                    k     <= i;
                    best  <= {CW{1'b1}};
                    bestk <= CW'(i);
                    state <= RD;
                end
                RD: state <= CMP;
                CMP: begin
                    // Strict compare keeps the smaller k on equal cost.
                    if (cost < best) begin
                        best  <= cost;
                        bestk <= CW'(k);
                    end
                    if (k == j - 5'd1) begin
                        state <= WR;
                    end else begin
                        k     <= k + 5'd1;
                        state <= RD;
                    end
                end
                WR: begin
                    if (len == {1'b0, nl}) begin
                        res_cost <= best;
                        res_k    <= bestk;
                    end
                    if ({1'b0, i} == {1'b0, nl} - len + 6'd1) begin
                        len   <= len + 6'd1;
                        i     <= 5'd1;
                        state <= (len == {1'b0, nl}) ? DONE : SETUP;
                    end else begin
                        i     <= i + 5'd1;
                        state <= SETUP;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
